// File: rtl/even_parity_serial_tx.sv
// even_parity_serial_tx: start/data(LSB first)/even-parity/stop serial framer; define PARITY_ERR_INJECT_EN to add err_inject for odd-parity frames
module even_parity_serial_tx #(
  parameter int DATA_W       = 3,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
`ifdef PARITY_ERR_INJECT_EN
  input  logic              err_inject,
`endif
  output logic              in_ready,
  output logic              tx,
  output logic              p,
  output logic              busy,
  output logic              done
);
  localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = DATA_W > 1 ? $clog2(DATA_W) : 1;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic              p_q, p_d, tx_q, tx_d;
  logic              inj, last;
`ifdef PARITY_ERR_INJECT_EN
  assign inj = err_inject;
`else
  assign inj = 1'b0;
`endif
  assign last     = cnt_q == CW'(CLKS_PER_BIT - 1);
  assign in_ready = state_q == IDLE;
  assign busy     = state_q != IDLE;
  assign done     = state_q == STOP && last;
  assign tx       = tx_q;
  assign p        = p_q;
  // next state: bit timing, data shifting, parity capture and the registered line level
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    p_d     = p_q;
    cnt_d   = (state_q == IDLE || last) ? '0 : cnt_q + CW'(1);
    case (state_q)
      IDLE: if (in_valid) begin
        state_d = START;
        sh_d    = in_data;
        p_d     = ^in_data ^ inj;
      end
      START:  if (last) state_d = DATA;
      DATA: if (last) begin
        sh_d    = sh_q >> 1;
        idx_d   = idx_q == IW'(DATA_W - 1) ? '0 : idx_q + IW'(1);
        state_d = idx_q == IW'(DATA_W - 1) ? PARITY : DATA;
      end
      PARITY: if (last) state_d = STOP;
      STOP:   if (last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    tx_d = state_d == START ? 1'b0 : state_d == DATA ? sh_d[0] : state_d == PARITY ? p_d : 1'b1;
  end
  // state register; reset abandons any frame and returns the line to idle-high
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      p_q     <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      p_q     <= p_d;
      tx_q    <= tx_d;
    end
  end
endmodule

// File: tb/tb_even_parity_serial_tx.sv
// tb_even_parity_serial_tx: randomized and directed frames checked against a frame-waveform model
module tb_even_parity_serial_tx;
  localparam int DW  = 3;
  localparam int CPB = 4;
  localparam int F   = (DW + 3) * CPB;
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready, tx, p, busy, done;
  int            n_chk = 0;
  int            n_pass = 0;
  int            pos = 0;
  logic          exp_p = 1'b0;
  logic          fb [DW+3];
  even_parity_serial_tx #(.DATA_W(DW), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .tx(tx), .p(p), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
  endtask
  task automatic cycle(input logic v, input logic [DW-1:0] d, input logic r);
    @(negedge clk);
    check("tx", 32'(tx), pos == 0 ? 32'd1 : 32'(fb[(pos - 1) / CPB]));
    check("in_ready", 32'(in_ready), 32'(pos == 0));
    check("busy", 32'(busy), 32'(pos != 0));
    check("done", 32'(done), 32'(pos == F));
    check("p", 32'(p), 32'(exp_p));
    in_valid = v;
    in_data  = d;
    rst      = r;
    @(posedge clk);
    if (r) begin
      pos   = 0;
      exp_p = 1'b0;
    end else if (pos == 0 && v) begin
      pos   = 1;
      exp_p = ^d;
      fb[0] = 1'b0;
      for (int i = 0; i < DW; i++) fb[1 + i] = d[i];
      fb[DW + 1] = ^d;
      fb[DW + 2] = 1'b1;
    end else if (pos != 0) pos = pos == F ? 0 : pos + 1;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    cycle(1'b0, '0, 1'b1);
    cycle(1'b1, 3'b011, 1'b0);
    repeat (F + 2) cycle(1'b0, DW'($urandom), 1'b0);
    cycle(1'b1, 3'b111, 1'b0);
    repeat (F + 2) cycle(1'b0, DW'($urandom), 1'b0);
    cycle(1'b1, 3'b000, 1'b0);
    repeat (F + 2) cycle(1'b1, DW'($urandom), 1'b0);
    repeat (5 * (F + 1)) cycle(1'b1, DW'($urandom), 1'b0);
    repeat (F + 2) cycle(1'b0, '0, 1'b0);
    cycle(1'b1, 3'b101, 1'b0);
    repeat (9) cycle(1'b0, DW'($urandom), 1'b0);
    cycle(1'b0, '0, 1'b1);
    cycle(1'b1, 3'b110, 1'b1);
    repeat (3) cycle(1'b0, '0, 1'b0);
    repeat (3000) cycle(($urandom % 3) == 0, DW'($urandom), ($urandom % 97) == 0);
    cycle(1'b0, '0, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
